// File: rtl/regfile_arbiter.sv
// regfile_arbiter
// Round-robin arbiter sharing the single query/modify port of the 32-entry,
// 64-bit architectural register file among NUM_REQ requesters (issue-stage
// operand lookups and commit write-back). One requester is granted per cycle;
// read data comes back one cycle later in a registered response.
//
// Ports:
//   clk_in             clock, all state on rising edge
//   rst_in             asynchronous active-high reset
//   rdy_in             global enable, low pauses arbitration
//   req_valid          per-requester request
//   req_write          per-requester 1 = modify, 0 = query
//   req_index          packed register indices, requester i at [5i+4:5i]
//   req_wdata          packed write data, requester i at [64i+63:64i]
//   req_grant          one-hot combinational grant
//   resp_valid         one-hot registered completion pulse
//   resp_data          read data for the requester flagged in resp_valid
//   rf_query_or_modify register file op: 0 query, 1 modify
//   rf_reg_index       register file index
//   rf_modify_value    register file write value
//   rf_query_value     register file combinational read data

module regfile_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int REG_SIZE = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [$clog2(REG_SIZE)*NUM_REQ-1:0] req_index,
  input  logic [64*NUM_REQ-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [63:0]                   resp_data,
  output logic                          rf_query_or_modify,
  output logic [$clog2(REG_SIZE)-1:0]   rf_reg_index,
  output logic [63:0]                   rf_modify_value,
  input  logic [63:0]                   rf_query_value
);

  localparam int IDX_W = $clog2(REG_SIZE);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] respValid_q, respValid_d;
  logic [63:0]        respData_q, respData_d;

  logic               grantFound;
  logic [PTR_W-1:0]   winIdx;
  logic [NUM_REQ-1:0] grantVec;
  logic               winWrite;
  logic [IDX_W-1:0]   winIndex;
  logic [63:0]        winData;

  // Round-robin search: first look at requesters at or above the pointer,
  // then wrap around to the lowest requester. Reset and pause suppress any
  // grant so nothing reaches the register file in those cycles.
  always_comb begin
    grantFound = 1'b0;
    winIdx     = '0;
    if (rdy_in && !rst_in) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grantFound && req_valid[i] && (i >= int'(ptr_q))) begin
          grantFound = 1'b1;
          winIdx     = PTR_W'(i);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grantFound && req_valid[i]) begin
          grantFound = 1'b1;
          winIdx     = PTR_W'(i);
        end
      end
    end
  end

  // Select the winner's fields; everything stays zero when nobody wins.
  always_comb begin
    grantVec = '0;
    winWrite = 1'b0;
    winIndex = '0;
    winData  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantFound && (winIdx == PTR_W'(i))) begin
        grantVec[i] = 1'b1;
        winWrite    = req_write[i];
        winIndex    = req_index[i*IDX_W +: IDX_W];
        winData     = req_wdata[i*64 +: 64];
      end
    end
  end

  // Next-state: pointer moves just past the winner; the response captures
  // register-file data for reads (x0 always reads as zero) and zero for writes.
  always_comb begin
    ptr_d       = ptr_q;
    respValid_d = grantVec;
    respData_d  = respData_q;
    if (grantFound) begin
      if (int'(winIdx) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = winIdx + 1'b1;
      end
      if (winWrite || (winIndex == '0)) begin
        respData_d = '0;
      end else begin
        respData_d = rf_query_value;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q       <= '0;
      respValid_q <= '0;
      respData_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      respValid_q <= respValid_d;
      respData_q  <= respData_d;
    end
  end

  // Writes to x0 are acknowledged but never reach the register file.
  assign rf_query_or_modify = grantFound && winWrite && (winIndex != '0);
  assign rf_reg_index       = winIndex;
  assign rf_modify_value    = winData;
  assign req_grant          = grantVec;
  assign resp_valid         = respValid_q;
  assign resp_data          = respData_q;

endmodule
